// File: rtl/mixed_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mixed_vec_pkg
// Description : Shared types and constants for the mixed-width vector
//               serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package mixed_vec_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] IDX_E0 = 2'd0;
    localparam logic [1:0] IDX_E1 = 2'd1;
    localparam logic [1:0] IDX_E2 = 2'd2;

    localparam int DEF_W0 = 4;
    localparam int DEF_W1 = 8;
    localparam int DEF_W2 = 16;

endpackage
`default_nettype wire

// File: rtl/mixed_vec_beat_mux.sv
`default_nettype none
// ============================================================================
// Module      : mixed_vec_beat_mux
// Description : Selects the held element for the current send state and
//               zero-extends it to the output beat width.
// Revision    : 1.0 - initial release
// ============================================================================
module mixed_vec_beat_mux
    import mixed_vec_pkg::*;
#(
    parameter int W0    = DEF_W0,
    parameter int W1    = DEF_W1,
    parameter int W2    = DEF_W2,
    parameter int OUT_W = 16
) (
    input  logic [2:0]       state,
    input  logic [W0-1:0]    e0,
    input  logic [W1-1:0]    e1,
    input  logic [W2-1:0]    e2,
    output logic [OUT_W-1:0] bits
);

    always_comb begin
        bits = '0;
        case (state_t'(state))
            SEND0:   bits[W0-1:0] = e0;
            SEND1:   bits[W1-1:0] = e1;
            SEND2:   bits[W2-1:0] = e2;
            default: bits = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mixed_vec_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mixed_vec_serializer
// Description : Accepts a three-element mixed-width vector and emits it one
//               element per beat; raises a sticky finish after NUM_VECS.
// Revision    : 1.0 - initial release
// ============================================================================
module mixed_vec_serializer
    import mixed_vec_pkg::*;
#(
    parameter int W0       = DEF_W0,
    parameter int W1       = DEF_W1,
    parameter int W2       = DEF_W2,
    parameter int OUT_W    = 16,
    parameter int NUM_VECS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W0-1:0]                 in_e0,
    input  logic [W1-1:0]                 in_e1,
    input  logic [W2-1:0]                 in_e2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_bits,
    output logic [1:0]                    out_idx,
    output logic                          out_last,
    output logic [$clog2(NUM_VECS+1)-1:0] vec_count,
    output logic                          finish
);

    localparam int c_cnt_w = $clog2(NUM_VECS + 1);
    localparam logic [c_cnt_w-1:0] c_num_vecs = c_cnt_w'(NUM_VECS);

    state_t             r_state;
    logic [W0-1:0]      r_e0;
    logic [W1-1:0]      r_e1;
    logic [W2-1:0]      r_e2;
    logic [c_cnt_w-1:0] r_vec_count;
    logic [c_cnt_w-1:0] w_next_count;

    assign w_next_count = r_vec_count + c_cnt_w'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_e0        <= '0;
            r_e1        <= '0;
            r_e2        <= '0;
            r_vec_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_e0    <= in_e0;
                        r_e1    <= in_e1;
                        r_e2    <= in_e2;
                        r_state <= SEND0;
                    end
                end
                SEND0: if (out_ready) r_state <= SEND1;
                SEND1: if (out_ready) r_state <= SEND2;
                SEND2: begin
                    // Count only completed vectors; DONE is terminal until reset.
                    if (out_ready) begin
                        r_vec_count <= w_next_count;
                        r_state     <= (w_next_count == c_num_vecs) ? DONE : IDLE;
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    mixed_vec_beat_mux #(
        .W0    (W0),
        .W1    (W1),
        .W2    (W2),
        .OUT_W (OUT_W)
    ) u_beat_mux (
        .state (r_state),
        .e0    (r_e0),
        .e1    (r_e1),
        .e2    (r_e2),
        .bits  (out_bits)
    );

    always_comb begin
        out_idx = IDX_E0;
        case (r_state)
            SEND1:   out_idx = IDX_E1;
            SEND2:   out_idx = IDX_E2;
            default: out_idx = IDX_E0;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == SEND0) || (r_state == SEND1) || (r_state == SEND2);
    assign out_last  = (r_state == SEND2);
    assign finish    = (r_state == DONE);
    assign vec_count = r_vec_count;

endmodule
`default_nettype wire
